snow64_icache_line_fill_responder: RTL

- Memory-side responder for the instruction cache's line-fill miss protocol.
- Accepts a one-cycle line request (req + address) and fetches the line as several narrow beats from the external memory port.
- Assembles the beats into a full cache line and returns it with a one-cycle valid pulse.
- Sits between the instruction cache's mem-access port and the system memory bus.

---
 rtl/snow64_icache_line_fill_responder_if.sv | 48 ++++
 rtl/snow64_icache_line_fill_responder.sv | 110 +++++++++++
 2 files changed

// File: rtl/snow64_icache_line_fill_responder_if.sv
// Bundles the cache-side request/response and memory-side beat signals of the
// instruction-cache line-fill responder.
interface snow64_icache_line_fill_responder_if #(
    parameter int unsigned WIDTH__ADDR     = 64,
    parameter int unsigned WIDTH__LINE     = 256,
    parameter int unsigned WIDTH__MEM_DATA = 64
);
    // Cache side
    logic                       in_req;
    logic [WIDTH__ADDR-1:0]     in_addr;
    logic                       out_valid;
    logic [WIDTH__LINE-1:0]     out_data;
    logic                       out_busy;
    logic                       out_err_overlap;
    // Memory side
    logic                       out_mem_req;
    logic [WIDTH__ADDR-1:0]     out_mem_addr;
    logic                       in_mem_valid;
    logic [WIDTH__MEM_DATA-1:0] in_mem_data;

    // Responder view
    modport slave (
        input  in_req,
        input  in_addr,
        input  in_mem_valid,
        input  in_mem_data,
        output out_valid,
        output out_data,
        output out_busy,
        output out_err_overlap,
        output out_mem_req,
        output out_mem_addr
    );

    // Environment view: cache plus memory
    modport master (
        output in_req,
        output in_addr,
        output in_mem_valid,
        output in_mem_data,
        input  out_valid,
        input  out_data,
        input  out_busy,
        input  out_err_overlap,
        input  out_mem_req,
        input  out_mem_addr
    );
endinterface

// File: rtl/snow64_icache_line_fill_responder.sv
// Instruction-cache line-fill responder: accepts a line request, reads the line
// from memory as NUM_BEATS narrow beats and returns the assembled line with a
// one-cycle valid pulse.
module snow64_icache_line_fill_responder #(
    parameter int unsigned WIDTH__ADDR     = 64,
    parameter int unsigned WIDTH__LINE     = 256,
    parameter int unsigned WIDTH__MEM_DATA = 64
) (
    input logic clk,
    input logic rst,
    snow64_icache_line_fill_responder_if.slave bus
);
    localparam int unsigned NUM_BEATS   = WIDTH__LINE / WIDTH__MEM_DATA;
    localparam int unsigned BEAT_BYTES  = WIDTH__MEM_DATA / 8;
    localparam int unsigned OFFSET_BITS = $clog2(WIDTH__LINE / 8);
    localparam int unsigned BEAT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    localparam logic [WIDTH__ADDR-1:0] OFFSET_MASK =
        {{(WIDTH__ADDR - OFFSET_BITS){1'b0}}, {OFFSET_BITS{1'b1}}};
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    typedef enum logic [0:0] {StIdle, StWaitBeat} state_e;

    state_e                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [WIDTH__LINE-1:0] line_buf_q, line_buf_d;
    logic [WIDTH__LINE-1:0] out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   mem_req_q, mem_req_d;
    logic [WIDTH__ADDR-1:0] mem_addr_q, mem_addr_d;
    logic                   err_q, err_d;

    // Next-state: request accept, beat capture/re-issue and line completion
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_buf_d  = line_buf_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        mem_req_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                // Beat data arriving while idle is stale and dropped
                if (bus.in_req) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = bus.in_addr & ~OFFSET_MASK;
                    beat_d     = '0;
                    state_d    = StWaitBeat;
                end
            end
            StWaitBeat: begin
                // A second request mid-fill is dropped but remembered
                if (bus.in_req) begin
                    err_d = 1'b1;
                end
                if (bus.in_mem_valid) begin
                    for (int k = 0; k < NUM_BEATS; k++) begin
                        if (beat_q == BEAT_W'(k)) begin
                            line_buf_d[k*WIDTH__MEM_DATA +: WIDTH__MEM_DATA] = bus.in_mem_data;
                        end
                    end
                    if (beat_q == LAST_BEAT) begin
                        out_data_d  = line_buf_d;
                        out_valid_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        beat_d     = beat_q + 1'b1;
                        mem_req_d  = 1'b1;
                        // Stays inside the line, so the offset field never carries out
                        mem_addr_d = mem_addr_q + WIDTH__ADDR'(BEAT_BYTES);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; reset discards any partial line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            line_buf_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_buf_q  <= line_buf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            err_q       <= err_d;
        end
    end

    assign bus.out_valid       = out_valid_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_busy        = (state_q != StIdle);
    assign bus.out_err_overlap = err_q;
    assign bus.out_mem_req     = mem_req_q;
    assign bus.out_mem_addr    = mem_addr_q;
endmodule
